// File: rtl/dmem_store_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_store_responder: store buffer draining into a word array, with         |
// | per-byte load forwarding and an external read port.   Revision: 1.0         |
// +----------------------------------------------------------------------------+
module dmem_store_responder #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_wr,
  input  logic [AW-1:0]              addr,
  input  logic [3:0]                 be,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata,
  input  logic                       ext_en,
  input  logic [AW-1:0]              ext_addr,
  output logic [31:0]                ext_rdata,
  output logic                       sb_full,
  output logic                       sb_empty,
  output logic [$clog2(DEPTH):0]     sb_count,
  output logic                       ovf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = 1 << AW;

  logic [AW-1:0] ent_addr_q [DEPTH];
  logic [AW-1:0] ent_addr_d [DEPTH];
  logic [3:0]    ent_be_q   [DEPTH];
  logic [3:0]    ent_be_d   [DEPTH];
  logic [31:0]   ent_data_q [DEPTH];
  logic [31:0]   ent_data_d [DEPTH];
  logic [31:0]   mem_q      [NW];
  logic [31:0]   mem_d      [NW];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          pop, push, drop, wr_req, full;

  always_comb begin
    full       = (count_q == CW'(DEPTH));
    pop        = (count_q != '0) && !ext_en;
    wr_req     = mem_wr && (be != 4'b0000);
    push       = wr_req && (!full || pop);
    drop       = wr_req && full && !pop;
    ent_addr_d = ent_addr_q;
    ent_be_d   = ent_be_q;
    ent_data_d = ent_data_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    ovf_d      = ovf_q | drop;
    // Slot written by push may be the one popped this edge when full; the pop reads _q.
    if (push) begin
      ent_addr_d[wr_ptr_q] = addr;
      ent_be_d[wr_ptr_q]   = be;
      ent_data_d[wr_ptr_q] = wdata;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      for (int l = 0; l < 4; l++) begin
        if (ent_be_q[rd_ptr_q][l]) begin
          mem_d[ent_addr_q[rd_ptr_q]][8*l +: 8] = ent_data_q[rd_ptr_q][8*l +: 8];
        end
      end
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Walk oldest to newest so the newest matching lane wins.
  always_comb begin : fwd
    logic [PW-1:0] idx;
    idx   = rd_ptr_q;
    rdata = mem_q[addr];
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (CW'(k) < count_q && ent_addr_q[idx] == addr) begin
        for (int l = 0; l < 4; l++) begin
          if (ent_be_q[idx][l]) begin
            rdata[8*l +: 8] = ent_data_q[idx][8*l +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_be_q[i]   <= '0;
        ent_data_q[i] <= '0;
      end
      for (int i = 0; i < NW; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ent_addr_q <= ent_addr_d;
      ent_be_q   <= ent_be_d;
      ent_data_q <= ent_data_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ext_rdata = mem_q[ext_addr];
  assign sb_full   = full;
  assign sb_empty  = (count_q == '0);
  assign sb_count  = count_q;
  assign ovf_err   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_store_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_store_responder: directed and random checks against a queue model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dmem_store_responder;

  localparam int DEPTH = 4;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_wr;
  logic [AW-1:0] addr;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          ext_en;
  logic [AW-1:0] ext_addr;
  logic [31:0]   ext_rdata;
  logic          sb_full, sb_empty, ovf_err;
  logic [2:0]    sb_count;

  dmem_store_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .mem_wr(mem_wr), .addr(addr), .be(be), .wdata(wdata),
    .rdata(rdata), .ext_en(ext_en), .ext_addr(ext_addr), .ext_rdata(ext_rdata),
    .sb_full(sb_full), .sb_empty(sb_empty), .sb_count(sb_count), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [3:0]    b;
    logic [31:0]   d;
  } st_t;

  logic [31:0] m_mem [1 << AW];
  st_t         m_q [$];
  logic        m_ovf;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic logic [31:0] m_rd(input logic [AW-1:0] a);
    logic [31:0] r;
    r = m_mem[a];
    foreach (m_q[i]) begin
      if (m_q[i].a == a) begin
        for (int l = 0; l < 4; l++) begin
          if (m_q[i].b[l]) r[8*l +: 8] = m_q[i].d[8*l +: 8];
        end
      end
    end
    return r;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < (1 << AW); i++) m_mem[i] = '0;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  // One clock: drive at negedge, check before the edge, advance the model at the edge.
  task automatic cycle(input logic w, input logic [AW-1:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic e, input logic [AW-1:0] ea);
    st_t s;
    mem_wr = w; addr = a; be = b; wdata = d; ext_en = e; ext_addr = ea;
    #1;
    check("rdata", rdata, m_rd(a));
    check("ext_rdata", ext_rdata, m_mem[ea]);
    check("sb_count", 32'(sb_count), 32'(m_q.size()));
    check("sb_full", 32'(sb_full), 32'(m_q.size() == DEPTH));
    check("sb_empty", 32'(sb_empty), 32'(m_q.size() == 0));
    check("ovf_err", 32'(ovf_err), 32'(m_ovf));
    @(posedge clk);
    begin
      logic pop_now, full_now;
      full_now = (m_q.size() == DEPTH);
      pop_now  = (m_q.size() != 0) && !e;
      if (pop_now) begin
        s = m_q.pop_front();
        for (int l = 0; l < 4; l++) if (s.b[l]) m_mem[s.a][8*l +: 8] = s.d[8*l +: 8];
      end
      if (w && b != 4'b0000) begin
        if (!full_now || pop_now) m_q.push_back('{a: a, b: b, d: d});
        else m_ovf = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic probe(input logic [AW-1:0] a, input logic [AW-1:0] ea, input logic e);
    mem_wr = 1'b0; addr = a; ext_addr = ea; ext_en = e;
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    mem_wr = 1'b0;
    m_clear();
    #1;
    check("rst_count", 32'(sb_count), 32'd0);
    check("rst_empty", 32'(sb_empty), 32'd1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_wr = 1'b0; addr = '0; be = '0; wdata = '0; ext_en = 1'b0; ext_addr = '0;
    m_clear();
    @(negedge clk);
    do_reset();

    probe(8'h00, 8'h00, 1'b0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_ext_rdata", ext_rdata, 32'h0);
    check("reset_empty", 32'(sb_empty), 32'd1);
    check("reset_full", 32'(sb_full), 32'd0);
    check("reset_ovf", 32'(ovf_err), 32'd0);

    // Single store, forwarded next cycle, committed the cycle after
    cycle(1'b1, 8'h10, 4'hF, 32'hDEADBEEF, 1'b0, 8'h10);
    probe(8'h10, 8'h10, 1'b0);
    check("fwd_single", rdata, 32'hDEADBEEF);
    check("ext_not_yet", ext_rdata, 32'h0);
    cycle(1'b0, 8'h10, 4'h0, 32'h0, 1'b0, 8'h10);
    probe(8'h10, 8'h10, 1'b0);
    check("ext_single", ext_rdata, 32'hDEADBEEF);
    check("empty_after_drain", 32'(sb_empty), 32'd1);

    // Fill with per-lane stores while draining is blocked
    cycle(1'b1, 8'h20, 4'b0001, 32'h00000011, 1'b1, 8'h20);
    cycle(1'b1, 8'h20, 4'b0010, 32'h00002200, 1'b1, 8'h20);
    cycle(1'b1, 8'h20, 4'b0100, 32'h00330000, 1'b1, 8'h20);
    cycle(1'b1, 8'h20, 4'b1000, 32'h44000000, 1'b1, 8'h20);
    probe(8'h20, 8'h20, 1'b1);
    check("full_flag", 32'(sb_full), 32'd1);
    check("full_count", 32'(sb_count), 32'd4);
    check("fwd_lanes", rdata, 32'h44332211);
    check("ext_blocked", ext_rdata, 32'h0);

    cycle(1'b1, 8'h20, 4'hF, 32'hFFFFFFFF, 1'b1, 8'h20);
    probe(8'h20, 8'h20, 1'b1);
    check("drop_ovf", 32'(ovf_err), 32'd1);
    check("drop_count", 32'(sb_count), 32'd4);
    check("drop_rdata", rdata, 32'h44332211);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h20, 4'h0, 32'h0, 1'b0, 8'h20);
    probe(8'h20, 8'h20, 1'b0);
    check("drained_empty", 32'(sb_empty), 32'd1);
    check("drained_ext", ext_rdata, 32'h44332211);
    check("ovf_sticky", 32'(ovf_err), 32'd1);

    // Overlapping stores: newer partial store wins its lanes
    cycle(1'b1, 8'h30, 4'b1111, 32'h11111111, 1'b1, 8'h30);
    cycle(1'b1, 8'h30, 4'b0011, 32'h0000AAAA, 1'b1, 8'h30);
    probe(8'h30, 8'h30, 1'b1);
    check("overlap_fwd", rdata, 32'h1111AAAA);
    cycle(1'b0, 8'h30, 4'h0, 32'h0, 1'b0, 8'h30);
    cycle(1'b0, 8'h30, 4'h0, 32'h0, 1'b0, 8'h30);
    probe(8'h30, 8'h30, 1'b0);
    check("overlap_ext", ext_rdata, 32'h1111AAAA);

    // Full with a simultaneous pop accepts the store; then reset mid-drain
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'h40 + 8'(i), 4'hF, $urandom, 1'b1, 8'h40);
    cycle(1'b1, 8'h44, 4'hF, 32'hCAFEF00D, 1'b0, 8'h40);
    probe(8'h44, 8'h40, 1'b1);
    check("push_pop_count", 32'(sb_count), 32'd4);
    check("push_pop_ovf", 32'(ovf_err), 32'd0);
    check("push_pop_fwd", rdata, 32'hCAFEF00D);
    cycle(1'b0, 8'h41, 4'h0, 32'h0, 1'b0, 8'h40);
    do_reset();
    for (int i = 0; i < (1 << AW); i++) begin
      probe(AW'(i), AW'(i), 1'b0);
      check("post_rst_rdata", rdata, 32'h0);
      check("post_rst_ext", ext_rdata, 32'h0);
    end
    @(negedge clk);

    // Random traffic over a small address window to force overlaps
    for (int n = 0; n < 600; n++) begin
      logic [AW-1:0] ra, rea;
      logic [3:0]    rb;
      ra  = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 5));
      rea = AW'($urandom_range(0, 5));
      rb  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      cycle($urandom_range(0, 9) < 7, ra, rb, $urandom, $urandom_range(0, 9) < 4, rea);
      if (n == 300) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
